// File: rtl/tt_mux_ctrl.sv
// Chip-side project multiplexer: pad select protocol, per-project reset sequencing,
// iw broadcast and ow return for the selected slot.
module tt_mux_ctrl #(
    parameter int N_PROJ  = 16,
    parameter int AW      = $clog2(N_PROJ),
    parameter int RST_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sel_clr,
    input  logic                   sel_inc,
    input  logic                   sel_ena,
    input  logic [17:0]            pad_iw,
    output logic [23:0]            pad_ow,
    output logic [17:0]            proj_iw,
    output logic [N_PROJ-1:0]      proj_ena,
    input  logic [N_PROJ*24-1:0]   proj_ow,
    output logic [AW-1:0]          sel_addr,
    output logic                   active
);

    localparam int CW = $clog2(RST_CYC + 2);

    typedef enum logic [1:0] {IDLE, HOLD, ACTIVE, DRAIN} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [AW-1:0]   act_addr;
    logic            load_act;

    logic clr_s1, clr_s2, inc_s1, inc_s2, inc_d, ena_s1, ena_s2;
    logic inc_rise;

    logic [N_PROJ-1:0] onehot;
    logic [23:0]       sel_ow;
    logic [N_PROJ-1:0] ena_nx;
    logic [17:0]       iw_nx;
    logic [23:0]       ow_nx;
    logic              active_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_s1 <= 1'b0; clr_s2 <= 1'b0;
            inc_s1 <= 1'b0; inc_s2 <= 1'b0; inc_d <= 1'b0;
            ena_s1 <= 1'b0; ena_s2 <= 1'b0;
        end else begin
            clr_s1 <= sel_clr; clr_s2 <= clr_s1;
            inc_s1 <= sel_inc; inc_s2 <= inc_s1; inc_d <= inc_s2;
            ena_s1 <= sel_ena; ena_s2 <= ena_s1;
        end
    end

    assign inc_rise = inc_s2 & ~inc_d;

    // Address only moves in IDLE; an inc coinciding with the enable request is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_addr <= '0;
        end else if (state == IDLE) begin
            if (clr_s2)
                sel_addr <= '0;
            else if (inc_rise && !ena_s2)
                sel_addr <= (sel_addr == AW'(N_PROJ - 1)) ? '0 : sel_addr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            act_addr <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load_act)
                act_addr <= sel_addr;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load_act = 1'b0;
        unique case (state)
            IDLE: begin
                if (ena_s2) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                    load_act = 1'b1;
                end
            end
            HOLD: begin
                if (!ena_s2) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else if (cnt == CW'(RST_CYC - 1)) begin
                    state_nx = ACTIVE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ACTIVE: begin
                if (!ena_s2) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end
            end
            DRAIN: begin
                if (cnt == CW'(1))
                    state_nx = IDLE;
                else
                    cnt_nx = cnt + CW'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        onehot = '0;
        sel_ow = '0;
        for (int unsigned k = 0; k < N_PROJ; k++) begin
            if (act_addr == AW'(k)) begin
                onehot[k] = 1'b1;
                sel_ow    = proj_ow[k*24 +: 24];
            end
        end
    end

    // Output values derived from the current state; registered below for a clean 1-cycle latency.
    always_comb begin
        ena_nx    = '0;
        iw_nx     = '0;
        ow_nx     = '0;
        active_nx = 1'b0;
        unique case (state)
            HOLD: begin
                ena_nx = onehot;
                iw_nx  = {pad_iw[17:2], 1'b0, pad_iw[0]};
            end
            ACTIVE: begin
                ena_nx    = onehot;
                iw_nx     = pad_iw;
                ow_nx     = sel_ow;
                active_nx = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proj_ena <= '0;
            proj_iw  <= '0;
            pad_ow   <= '0;
            active   <= 1'b0;
        end else begin
            proj_ena <= ena_nx;
            proj_iw  <= iw_nx;
            pad_ow   <= ow_nx;
            active   <= active_nx;
        end
    end

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Directed bench for tt_mux_ctrl: stimulus pushes time-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_tt_mux_ctrl;

    localparam int N_PROJ  = 16;
    localparam int AW      = 4;
    localparam int RST_CYC = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sel_clr, sel_inc, sel_ena;
    logic [17:0]          pad_iw;
    logic [23:0]          pad_ow;
    logic [17:0]          proj_iw;
    logic [N_PROJ-1:0]    proj_ena;
    logic [N_PROJ*24-1:0] proj_ow;
    logic [AW-1:0]        sel_addr;
    logic                 active;

    tt_mux_ctrl #(.N_PROJ(N_PROJ), .AW(AW), .RST_CYC(RST_CYC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_clr  (sel_clr),
        .sel_inc  (sel_inc),
        .sel_ena  (sel_ena),
        .pad_iw   (pad_iw),
        .pad_ow   (pad_ow),
        .proj_iw  (proj_iw),
        .proj_ena (proj_ena),
        .proj_ow  (proj_ow),
        .sel_addr (sel_addr),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       tag;
        logic [3:0]  addr;
        logic [15:0] ena;
        logic [17:0] iw;
        logic [23:0] ow;
        logic        act;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string tag, input string fld, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s cyc=%0d got=%h want=%h", tag, fld, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s.late due=%0d now=%0d", e.tag, e.due, cyc);
            end else begin
                cmp(e.tag, "sel_addr", 32'(sel_addr), 32'(e.addr));
                cmp(e.tag, "proj_ena", 32'(proj_ena), 32'(e.ena));
                cmp(e.tag, "proj_iw",  32'(proj_iw),  32'(e.iw));
                cmp(e.tag, "pad_ow",   32'(pad_ow),   32'(e.ow));
                cmp(e.tag, "active",   32'(active),   32'(e.act));
            end
        end
    end

    task automatic expect_at(input string tag, input int dly, input logic [3:0] addr,
                             input logic [15:0] ena, input logic [17:0] iw,
                             input logic [23:0] ow, input logic act);
        exp_t e;
        e.due = cyc + dly; e.tag = tag; e.addr = addr; e.ena = ena;
        e.iw = iw; e.ow = ow; e.act = act;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        sel_inc = 1'b1; tick(1);
        sel_inc = 1'b0; tick(1);
    endtask

    task automatic set_slot(input int k, input logic [23:0] v);
        proj_ow[k*24 +: 24] = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel_clr = 1'b0; sel_inc = 1'b0; sel_ena = 1'b0;
        pad_iw = '0;
        proj_ow = '1;
        set_slot(5, 24'hA5C33C);
        tick(2);
        expect_at("reset", 0, 4'd0, 16'h0, 18'h0, 24'h0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // 1: increment latency is exactly 3 cycles from the pad edge
        pulse();
        expect_at("inc_lat_pre", 0, 4'd0, 16'h0, 18'h0, 24'h0, 1'b0);
        expect_at("inc_lat",     1, 4'd1, 16'h0, 18'h0, 24'h0, 1'b0);
        pulse(); pulse();
        tick(3);
        expect_at("t1_addr3", 0, 4'd3, 16'h0, 18'h0, 24'h0, 1'b0);

        // 2: clear, count to the last slot, wrap, clear beating a pending inc
        sel_clr = 1'b1; tick(4); sel_clr = 1'b0; tick(3);
        expect_at("t2_clr", 0, 4'd0, 16'h0, 18'h0, 24'h0, 1'b0);
        for (int i = 0; i < N_PROJ - 1; i++) pulse();
        tick(3);
        expect_at("t2_max", 0, 4'd15, 16'h0, 18'h0, 24'h0, 1'b0);
        pulse(); tick(3);
        expect_at("t2_wrap", 0, 4'd0, 16'h0, 18'h0, 24'h0, 1'b0);
        pulse(); pulse(); tick(3);
        expect_at("t2_addr2", 0, 4'd2, 16'h0, 18'h0, 24'h0, 1'b0);
        sel_clr = 1'b1; sel_inc = 1'b1; tick(1);
        sel_inc = 1'b0; tick(4);
        sel_clr = 1'b0; tick(3);
        expect_at("t2_clr_inc", 0, 4'd0, 16'h0, 18'h0, 24'h0, 1'b0);

        // 3: select slot 5, reset held RST_CYC cycles then released
        for (int i = 0; i < 5; i++) pulse();
        tick(3);
        expect_at("t3_addr5", 0, 4'd5, 16'h0, 18'h0, 24'h0, 1'b0);
        pad_iw = 18'h3FFFF;
        sel_ena = 1'b1;
        expect_at("t3_idle", 3, 4'd5, 16'h0, 18'h0, 24'h0, 1'b0);
        for (int i = 4; i < 4 + RST_CYC; i++)
            expect_at("t3_hold", i, 4'd5, 16'h0020, 18'h3FFFD, 24'h0, 1'b0);
        expect_at("t3_active", 4 + RST_CYC, 4'd5, 16'h0020, 18'h3FFFF, 24'hA5C33C, 1'b1);
        tick(4 + RST_CYC + 1);

        // 4: ow/iw follow with one cycle latency; inc pulses ignored outside IDLE
        set_slot(5, 24'h123456);
        pad_iw = 18'h2AAAA;
        expect_at("t4_old", 0, 4'd5, 16'h0020, 18'h3FFFF, 24'hA5C33C, 1'b1);
        expect_at("t4_new", 1, 4'd5, 16'h0020, 18'h2AAAA, 24'h123456, 1'b1);
        tick(2);
        pulse(); pulse(); tick(3);
        expect_at("t4_noinc", 0, 4'd5, 16'h0020, 18'h2AAAA, 24'h123456, 1'b1);
        tick(1);

        // 5: drop enable, re-raise during DRAIN; HOLD only after an IDLE cycle
        sel_ena = 1'b0;
        expect_at("t5_still", 3, 4'd5, 16'h0020, 18'h2AAAA, 24'h123456, 1'b1);
        expect_at("t5_drain1", 4, 4'd5, 16'h0, 18'h0, 24'h0, 1'b0);
        expect_at("t5_drain2", 5, 4'd5, 16'h0, 18'h0, 24'h0, 1'b0);
        expect_at("t5_idle",   6, 4'd5, 16'h0, 18'h0, 24'h0, 1'b0);
        expect_at("t5_hold",   7, 4'd5, 16'h0020, 18'h2AAA8, 24'h0, 1'b0);
        tick(2);
        sel_ena = 1'b1;
        tick(6);

        // 6: async reset during HOLD
        rst_n = 1'b0;
        expect_at("t6_rst", 0, 4'd0, 16'h0, 18'h0, 24'h0, 1'b0);
        tick(2);
        sel_ena = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        expect_at("t6_post", 0, 4'd0, 16'h0, 18'h0, 24'h0, 1'b0);
        expect_at("t6_idle", 5, 4'd0, 16'h0, 18'h0, 24'h0, 1'b0);
        tick(7);

        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pending_expectations left=%0d", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
